// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - N-channel PWM bank with shared prescaled period counter
// Duties are shadowed per channel and committed together at period wrap.
module pwm_bank #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int PSW = 8,
  parameter int CHW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    cfg_period,
  input  logic [PSW-1:0]   cfg_prescale,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [NCH-1:0]   ch_invert,
  input  logic             gate,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [CW-1:0]    wr_duty,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_start,
  output logic [NCH-1:0]   pending
);

  logic [PSW-1:0] pre_cnt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  shadow [NCH];
  logic [CW-1:0]  active [NCH];
  logic           gate_m;
  logic           gate_s;
  logic           rdy_en;
  logic           tick;
  logic           wrap;
  logic           wr_fire;

  // >= rather than == so that lowering either config below the live count
  // forces an immediate tick/wrap instead of a full counter roll-over.
  assign tick     = (pre_cnt >= cfg_prescale);
  assign wrap     = tick && (cnt >= cfg_period);
  assign wr_ready = rdy_en && !wrap;
  assign wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      gate_m       <= 1'b0;
      gate_s       <= 1'b0;
      rdy_en       <= 1'b0;
      period_start <= 1'b0;
      pending      <= '0;
      pwm_out      <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      rdy_en       <= 1'b1;
      gate_m       <= gate;
      gate_s       <= gate_m;
      pre_cnt      <= tick ? '0 : pre_cnt + PSW'(1);
      period_start <= wrap;
      if (tick) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
      end
      for (int i = 0; i < NCH; i++) begin
        // wr_ready is low on wrap cycles, so commit and write never collide
        if (wrap && pending[i]) begin
          active[i]  <= shadow[i];
          pending[i] <= 1'b0;
        end else if (wr_fire && (wr_ch == CHW'(i))) begin
          shadow[i]  <= wr_duty;
          pending[i] <= 1'b1;
        end
        pwm_out[i] <= (ch_enable[i] && gate_s) ? ((cnt < active[i]) ^ ch_invert[i])
                                               : ch_invert[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - self-checking bench for pwm_bank
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_period = 8'd9;
  logic [7:0] cfg_prescale = 8'd0;
  logic [3:0] ch_enable = 4'b0001;
  logic [3:0] ch_invert = 4'b0000;
  logic       gate = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_ch = 2'd0;
  logic [7:0] wr_duty = 8'd0;
  logic [3:0] pwm_out;
  logic       period_start;
  logic [3:0] pending;

  int n_vec = 0;
  int n_bad = 0;

  pwm_bank #(.NCH(4), .CW(8), .PSW(8), .CHW(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_period(cfg_period), .cfg_prescale(cfg_prescale),
    .ch_enable(ch_enable), .ch_invert(ch_invert), .gate(gate),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_out), .period_start(period_start), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         p;
    int         t;
    logic [7:0] duty;
    logic       en;
    logic       inv;
    int         exp_len;
    int         exp_hi;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timeout", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_duty(input logic [1:0] ch, input logic [7:0] d);
    int k = 0;
    wr_ch = ch;
    wr_duty = d;
    wr_valid = 1'b1;
    while (!wr_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) timeout("write_accept");
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 500);
    if (!period_start) timeout("wait_period_start");
  endtask

  // Called on a period_start sample; counts one full period of samples.
  task automatic measure(input int ch, output int len, output int hi);
    len = 0;
    hi = 0;
    do begin
      @(negedge clk);
      len++;
      hi += int'(pwm_out[ch]);
    end while (!period_start && len < 500);
  endtask

  vec_t vecs[$];

  initial begin
    int len, hi, k;
    int P, T, L, cnt_c;
    logic [7:0] sh[4];
    logic [7:0] ac[4];
    logic [3:0] pd, exp_pwm;
    logic exp_ps, wrap_c, rdy;

    vecs.push_back('{0, 9, 8'd3,  1'b1, 1'b0, 10, 3});
    vecs.push_back('{0, 9, 8'd0,  1'b1, 1'b0, 10, 0});
    vecs.push_back('{0, 9, 8'd10, 1'b1, 1'b0, 10, 10});
    vecs.push_back('{3, 9, 8'd3,  1'b1, 1'b0, 40, 12});
    vecs.push_back('{0, 9, 8'd3,  1'b0, 1'b1, 10, 10});
    vecs.push_back('{0, 9, 8'd3,  1'b0, 1'b0, 10, 0});
    vecs.push_back('{0, 9, 8'd3,  1'b1, 1'b1, 10, 7});
    vecs.push_back('{1, 0, 8'd1,  1'b1, 1'b0, 2, 2});
    vecs.push_back('{1, 4, 8'd2,  1'b1, 1'b0, 10, 4});

    #1;
    chk("reset_pwm", pwm_out, 0);
    chk("reset_ready", wr_ready, 0);
    chk("reset_pending", pending, 0);
    chk("reset_ps", period_start, 0);

    foreach (vecs[v]) begin
      cfg_prescale = 8'(vecs[v].p);
      cfg_period = 8'(vecs[v].t);
      ch_enable = {3'b000, vecs[v].en};
      ch_invert = {3'b000, vecs[v].inv};
      do_reset();
      write_duty(2'd0, vecs[v].duty);
      wait_ps();
      wait_ps();
      measure(0, len, hi);
      chk($sformatf("row%0d_len", v), len, vecs[v].exp_len);
      chk($sformatf("row%0d_high", v), hi, vecs[v].exp_hi);
    end

    // write mid-period stays pending until the wrap
    cfg_prescale = 8'd0; cfg_period = 8'd9; ch_enable = 4'b0010; ch_invert = 4'b0000;
    do_reset();
    wait_ps();
    repeat (4) @(negedge clk);
    write_duty(2'd1, 8'd5);
    chk("mid_pending_set", pending[1], 1);
    hi = 0; k = 0;
    while (!period_start && k < 50) begin
      hi += int'(pwm_out[1]);
      @(negedge clk);
      k++;
    end
    chk("mid_unchanged", hi, 0);
    chk("mid_pending_clr", pending[1], 0);
    measure(1, len, hi);
    chk("mid_high", hi, 5);

    // lowering the period below the live count wraps on the next tick
    cfg_prescale = 8'd3; cfg_period = 8'd9; ch_enable = 4'b0001;
    do_reset();
    write_duty(2'd0, 8'd3);
    wait_ps();
    repeat (28) @(negedge clk);
    cfg_period = 8'd2;
    #1;
    chk("lower_ready", wr_ready, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 100);
    chk("lower_wrap_delay", k, 4);
    measure(0, len, hi);
    chk("lower_len", len, 12);

    // gate drop reaches the pins after three clocks
    cfg_prescale = 8'd0; cfg_period = 8'd9; ch_enable = 4'b0101; ch_invert = 4'b0100;
    do_reset();
    write_duty(2'd0, 8'd10);
    write_duty(2'd2, 8'd10);
    wait_ps();
    wait_ps();
    @(negedge clk);
    chk("gate_before", pwm_out, 4'b0001);
    gate = 1'b0;
    repeat (2) @(negedge clk);
    chk("gate_2clk", pwm_out, 4'b0001);
    @(negedge clk);
    chk("gate_3clk", pwm_out, 4'b0100);
    gate = 1'b1;

    // write offered on the wrap cycle is deferred by one clock
    ch_enable = 4'b0001; ch_invert = 4'b0000;
    do_reset();
    write_duty(2'd0, 8'd3);
    wait_ps();
    wait_ps();
    repeat (9) @(negedge clk);
    wr_ch = 2'd0; wr_duty = 8'd6; wr_valid = 1'b1;
    #1;
    chk("wrapwr_ready0", wr_ready, 0);
    @(negedge clk);
    chk("wrapwr_ps", period_start, 1);
    chk("wrapwr_ready1", wr_ready, 1);
    chk("wrapwr_notyet", pending[0], 0);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wrapwr_pending", pending[0], 1);
    wait_ps();
    measure(0, len, hi);
    chk("wrapwr_high", hi, 6);

    // asynchronous reset mid-period
    @(negedge clk);
    chk("areset_high_before", pwm_out[0], 1);
    write_duty(2'd0, 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_pwm", pwm_out, 0);
    chk("areset_ready", wr_ready, 0);
    chk("areset_pending", pending, 0);
    chk("areset_ps", period_start, 0);

    // randomized runs with fixed config against a closed-form timing model
    for (int trial = 0; trial < 6; trial++) begin
      P = $urandom_range(0, 3);
      T = $urandom_range(0, 12);
      L = (P + 1) * (T + 1);
      cfg_prescale = 8'(P);
      cfg_period = 8'(T);
      ch_enable = 4'($urandom);
      ch_invert = 4'($urandom);
      gate = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
        sh[i] = '0;
        ac[i] = '0;
      end
      pd = '0; exp_pwm = '0; exp_ps = 1'b0;
      for (int c = 0; c < 200; c++) begin
        wrap_c = ((c + 1) % L == 0);
        rdy = (c >= 1) && !wrap_c;
        chk("rnd_pwm", pwm_out, exp_pwm);
        chk("rnd_ps", period_start, exp_ps);
        chk("rnd_pending", pending, pd);
        chk("rnd_ready", wr_ready, rdy);
        wr_valid = ($urandom_range(0, 2) == 0);
        wr_ch = 2'($urandom);
        wr_duty = 8'($urandom_range(0, T + 2));
        cnt_c = (c / (P + 1)) % (T + 1);
        for (int i = 0; i < 4; i++)
          exp_pwm[i] = (ch_enable[i] && c >= 2) ? ((cnt_c < int'(ac[i])) ^ ch_invert[i])
                                                : ch_invert[i];
        exp_ps = wrap_c;
        if (wrap_c) begin
          for (int i = 0; i < 4; i++)
            if (pd[i]) begin
              ac[i] = sh[i];
              pd[i] = 1'b0;
            end
        end else if (wr_valid && rdy) begin
          sh[wr_ch] = wr_duty;
          pd[wr_ch] = 1'b1;
        end
        @(negedge clk);
      end
      wr_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
